inhibit_tt_sequencer: RTL and testbench

Sequential truth-table driver and checker for the two-input inhibit function s = a & ~b, built to wrap a pair of implementations of that function: the behavioural form and the NOR-only equivalent. It sits directly upstream, driving the a/b operands, and directly downstream, sampling both s outputs. On each start it sweeps the four input vectors 00, 01, 10, 11 for a configurable number of passes. At each vector it compares both outputs against the expected value, then reports pass/fail, a saturating mismatch count and the first failing vector.

---
 rtl/inhibit_tt_sequencer.sv | 154 +++++++++++++++
 tb/tb_inhibit_tt_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inhibit_tt_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : inhibit_tt_sequencer
// Description : Truth-table driver and checker for the inhibit function
//               s = a & ~b. Sweeps the vectors 00, 01, 10, 11 for N_PASSES
//               passes. Each vector is held for SETTLE cycles before it is
//               sampled. Both implementation outputs are compared against
//               the expected value. The block reports pass/fail, a saturating
//               mismatch count and the first failing vector.
// Parameters  : SETTLE   (1..15) drive cycles per vector before sampling
//               N_PASSES (1..15) full 4-vector sweeps per run
// Ports       : clk, reset (sync, active-high), start,
//               a/b        operands to both implementations,
//               s_base/s_eq results from both implementations,
//               busy, done, pass, err_count[3:0], vec_idx[1:0],
//               first_fail[2:0] = {valid, a, b}
// Option      : INHIBIT_TT_STOP_ON_FAIL_EN - when defined, the first
//               mismatch ends the run immediately.
// Revision    : 1.0 - initial release
// ============================================================================
module inhibit_tt_sequencer #(
    parameter int SETTLE   = 1,
    parameter int N_PASSES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic       s_base,
    input  logic       s_eq,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [1:0] vec_idx,
    output logic [2:0] first_fail
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_drive  = 2'd1;
    localparam logic [1:0] c_st_sample = 2'd2;
    localparam logic [1:0] c_st_done   = 2'd3;

    localparam logic [3:0] c_settle_init = 4'(SETTLE - 1);
    localparam logic [3:0] c_last_pass   = 4'(N_PASSES - 1);

    logic [1:0] r_state;
    logic [3:0] r_settle;
    logic [3:0] r_pass_cnt;
    logic [1:0] r_vec_idx;
    logic [3:0] r_err_count;
    logic [2:0] r_first_fail;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;

    logic       w_expected;
    logic       w_mismatch;
    logic [3:0] w_err_next;
    logic       w_last_vec;
    logic       w_stop;

    // The operands come straight from the vector index register, so they are
    // stable for the whole DRIVE+SAMPLE window of a vector.
    assign w_expected = r_vec_idx[1] & ~r_vec_idx[0];
    assign w_mismatch = (s_base != w_expected) | (s_eq != w_expected);
    assign w_err_next = (w_mismatch && (r_err_count != 4'd15)) ?
                        (r_err_count + 4'd1) : r_err_count;
    assign w_last_vec = (r_vec_idx == 2'd3) && (r_pass_cnt == c_last_pass);

`ifdef INHIBIT_TT_STOP_ON_FAIL_EN
    assign w_stop = w_mismatch;
`else
    assign w_stop = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_st_idle;
            r_settle     <= 4'd0;
            r_pass_cnt   <= 4'd0;
            r_vec_idx    <= 2'd0;
            r_err_count  <= 4'd0;
            r_first_fail <= 3'b000;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_state      <= c_st_drive;
                        r_settle     <= c_settle_init;
                        r_pass_cnt   <= 4'd0;
                        r_vec_idx    <= 2'd0;
                        r_err_count  <= 4'd0;
                        r_first_fail <= 3'b000;
                        r_busy       <= 1'b1;
                        r_pass       <= 1'b1;
                    end
                end
                c_st_drive: begin
                    if (r_settle == 4'd0) begin
                        r_state <= c_st_sample;
                    end else begin
                        r_settle <= r_settle - 4'd1;
                    end
                end
                c_st_sample: begin
                    r_err_count <= w_err_next;
                    if (w_mismatch && !r_first_fail[2]) begin
                        r_first_fail <= {1'b1, r_vec_idx};
                    end
                    if (w_stop || w_last_vec) begin
                        // Result registers settle on this edge, so they are
                        // already final while done is high.
                        r_state <= c_st_done;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_next == 4'd0);
                    end else begin
                        r_state  <= c_st_drive;
                        r_settle <= c_settle_init;
                        if (r_vec_idx == 2'd3) begin
                            r_vec_idx  <= 2'd0;
                            r_pass_cnt <= r_pass_cnt + 4'd1;
                        end else begin
                            r_vec_idx <= r_vec_idx + 2'd1;
                        end
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign a          = r_vec_idx[1];
    assign b          = r_vec_idx[0];
    assign vec_idx    = r_vec_idx;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;
    assign err_count  = r_err_count;
    assign first_fail = r_first_fail;

endmodule
`default_nettype wire

// File: tb/tb_inhibit_tt_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_inhibit_tt_sequencer
// Description : Scoreboard bench for inhibit_tt_sequencer. Three instances
//               cover the parameter sets (defaults, SETTLE=2/N_PASSES=3,
//               N_PASSES=5). The bench models the wrapped implementations
//               with selectable faults. Expected run results are queued at
//               start, and a monitor pops and compares them on every done
//               pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inhibit_tt_sequencer;

    // Fault modes for the modelled implementations
    localparam int c_ok         = 0;
    localparam int c_eq_stuck0  = 1;
    localparam int c_base_stk1  = 2;
    localparam int c_base_inv   = 3;
    localparam int c_eq_stuck1  = 4;

    typedef struct {
        int dut;
        int err;
        int ff;
        int pas;
        int cyc;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [2:0] r_start;
    logic [2:0] w_a;
    logic [2:0] w_b;
    logic [2:0] w_s_base;
    logic [2:0] w_s_eq;
    logic [2:0] w_busy;
    logic [2:0] w_done;
    logic [2:0] w_pass;
    logic [3:0] w_err  [3];
    logic [1:0] w_vec  [3];
    logic [2:0] w_ff   [3];
    int         r_mode [3];

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   n_done [3] = '{0, 0, 0};
    exp_t exp_q [$];
    exp_t m_e;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic model_s(input int mode, input logic av,
                                     input logic bv, input logic is_eq);
        logic s;
        s = av & ~bv;
        if (is_eq) begin
            if (mode == c_eq_stuck0) s = 1'b0;
            if (mode == c_eq_stuck1) s = 1'b1;
        end else begin
            if (mode == c_base_stk1) s = 1'b1;
            if (mode == c_base_inv)  s = ~s;
        end
        return s;
    endfunction

    assign w_s_base[0] = model_s(r_mode[0], w_a[0], w_b[0], 1'b0);
    assign w_s_eq[0]   = model_s(r_mode[0], w_a[0], w_b[0], 1'b1);
    assign w_s_base[1] = model_s(r_mode[1], w_a[1], w_b[1], 1'b0);
    assign w_s_eq[1]   = model_s(r_mode[1], w_a[1], w_b[1], 1'b1);
    assign w_s_base[2] = model_s(r_mode[2], w_a[2], w_b[2], 1'b0);
    assign w_s_eq[2]   = model_s(r_mode[2], w_a[2], w_b[2], 1'b1);

    inhibit_tt_sequencer #(.SETTLE(1), .N_PASSES(1)) u_dut0 (
        .clk(clk), .reset(reset), .start(r_start[0]), .a(w_a[0]), .b(w_b[0]),
        .s_base(w_s_base[0]), .s_eq(w_s_eq[0]), .busy(w_busy[0]),
        .done(w_done[0]), .pass(w_pass[0]), .err_count(w_err[0]),
        .vec_idx(w_vec[0]), .first_fail(w_ff[0]));

    inhibit_tt_sequencer #(.SETTLE(2), .N_PASSES(3)) u_dut1 (
        .clk(clk), .reset(reset), .start(r_start[1]), .a(w_a[1]), .b(w_b[1]),
        .s_base(w_s_base[1]), .s_eq(w_s_eq[1]), .busy(w_busy[1]),
        .done(w_done[1]), .pass(w_pass[1]), .err_count(w_err[1]),
        .vec_idx(w_vec[1]), .first_fail(w_ff[1]));

    inhibit_tt_sequencer #(.SETTLE(1), .N_PASSES(5)) u_dut2 (
        .clk(clk), .reset(reset), .start(r_start[2]), .a(w_a[2]), .b(w_b[2]),
        .s_base(w_s_base[2]), .s_eq(w_s_eq[2]), .busy(w_busy[2]),
        .done(w_done[2]), .pass(w_pass[2]), .err_count(w_err[2]),
        .vec_idx(w_vec[2]), .first_fail(w_ff[2]));

    task automatic chk(input string name, input int act, input int req);
        checks = checks + 1;
        if (act != req) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every done pulse consumes one queued expectation.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (w_done[d]) begin
                n_done[d] = n_done[d] + 1;
                if (exp_q.size() == 0) begin
                    checks = checks + 1;
                    errors = errors + 1;
                    $display("FAIL unexpected_done dut=%0d actual=1 required=0", d);
                end else begin
                    m_e = exp_q.pop_front();
                    chk("done_dut",   d,              m_e.dut);
                    chk("err_count",  int'(w_err[d]), m_e.err);
                    chk("first_fail", int'(w_ff[d]),  m_e.ff);
                    chk("pass",       int'(w_pass[d]), m_e.pas);
                    chk("done_cycle", cyc,            m_e.cyc);
                end
            end
        end
    end

    task automatic wait_done(input int d, input int target, input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            if (n_done[d] >= target) break;
            @(negedge clk);
            #1;
        end
        if (n_done[d] < target) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL done_timeout dut=%0d actual=%0d required=%0d", d, n_done[d], target);
        end
    endtask

    // One run: start pulse sampled at edge t0, result expected after lat edges.
    task automatic run(input int d, input int mode, input int err, input int ff,
                       input int pas, input int lat);
        int t0;
        int n0;
        exp_t e;
        n0        = n_done[d];
        r_mode[d] = mode;
        r_start[d] = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        r_start[d] = 1'b0;
        e = '{dut: d, err: err, ff: ff, pas: pas, cyc: t0 + lat};
        exp_q.push_back(e);
        wait_done(d, n0 + 1, lat + 20);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int t0;
        int n0;
        exp_t e;
        reset   = 1'b1;
        r_start = 3'b000;
        r_mode  = '{c_ok, c_ok, c_ok};
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        chk("rst_busy", int'(w_busy[0]), 0);
        chk("rst_done", int'(w_done[0]), 0);
        chk("rst_pass", int'(w_pass[0]), 1);
        chk("rst_err",  int'(w_err[0]),  0);
        chk("rst_ff",   int'(w_ff[0]),   0);
        chk("rst_ab",   int'({w_a[0], w_b[0]}), 0);

        // Correct implementations, defaults: vector sequence and timing
        n0 = n_done[0];
        r_mode[0]  = c_ok;
        r_start[0] = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        r_start[0] = 1'b0;
        e = '{dut: 0, err: 0, ff: 0, pas: 1, cyc: t0 + 8};
        exp_q.push_back(e);
        chk("busy_after_start", int'(w_busy[0]), 1);
        for (int k = 1; k <= 8; k++) begin
            chk("vec_ab", int'({w_a[0], w_b[0]}), (k - 1) / 2);
            chk("vec_idx", int'(w_vec[0]), (k - 1) / 2);
            @(posedge clk);
            #1;
        end
        chk("busy_in_done", int'(w_busy[0]), 0);
        wait_done(0, n0 + 1, 20);
        repeat (2) @(posedge clk);
        #1;

`ifdef INHIBIT_TT_STOP_ON_FAIL_EN
        run(0, c_eq_stuck0, 1, 3'b110, 0, 6);
        run(1, c_base_stk1, 1, 3'b100, 0, 3);
        run(2, c_base_inv,  1, 3'b100, 0, 2);
        run(0, c_eq_stuck1, 1, 3'b100, 0, 2);
`else
        run(0, c_eq_stuck0, 1, 3'b110, 0, 8);
        run(1, c_base_stk1, 9, 3'b100, 0, 36);
        run(2, c_base_inv,  15, 3'b100, 0, 40);
        run(0, c_eq_stuck1, 3, 3'b100, 0, 8);
`endif

        // Reset during SAMPLE of vector 01 (s_base stuck 1 gives err=1 by then)
        r_mode[0]  = c_base_stk1;
        r_start[0] = 1'b1;
        @(posedge clk);
        #1;
        r_start[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_vec", int'(w_vec[0]), 1);
        chk("pre_rst_err", int'(w_err[0]), 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort_busy", int'(w_busy[0]), 0);
        chk("abort_ab",   int'({w_a[0], w_b[0]}), 0);
        chk("abort_err",  int'(w_err[0]),  0);
        chk("abort_done", int'(w_done[0]), 0);
        chk("abort_ff",   int'(w_ff[0]),   0);
        chk("abort_pass", int'(w_pass[0]), 1);
        repeat (12) @(posedge clk);
        #1;
        run(0, c_ok, 0, 3'b000, 1, 8);

        // start held high: back-to-back runs with one IDLE cycle between
        n0 = n_done[0];
        r_mode[0]  = c_ok;
        r_start[0] = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        e = '{dut: 0, err: 0, ff: 0, pas: 1, cyc: t0 + 8};
        exp_q.push_back(e);
        e = '{dut: 0, err: 0, ff: 0, pas: 1, cyc: t0 + 18};
        exp_q.push_back(e);
        repeat (9) @(posedge clk);
        #1;
        chk("b2b_idle_busy", int'(w_busy[0]), 0);
        chk("b2b_idle_done", int'(w_done[0]), 0);
        @(posedge clk);
        #1;
        chk("b2b_restart_busy", int'(w_busy[0]), 1);
        r_start[0] = 1'b0;
        wait_done(0, n0 + 2, 40);
        repeat (4) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
